// File: rtl/pixel_zone_scanner.sv
// Raster scanner: reads a binary image from the pixel buffer and accumulates
// per-zone ink counts, total ink and the ink bounding box.
module pixel_zone_scanner #(
   parameter int IMG_W   = 28,
   parameter int IMG_H   = 28,
   parameter int ZONES_X = 4,
   parameter int ZONES_Y = 4,
   parameter int ADDR_W  = 10,
   parameter int COORD_W = 5,
   parameter int CNT_W   = 8,
   parameter int ZSEL_W  = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               dark_level,
   input  logic               pixel,
   output logic [ADDR_W-1:0]  pixel_addr,
   input  logic [ZSEL_W-1:0]  zone_sel,
   output logic [CNT_W-1:0]   zone_count,
   output logic [ADDR_W:0]    total_count,
   output logic [COORD_W-1:0] x_min,
   output logic [COORD_W-1:0] x_max,
   output logic [COORD_W-1:0] y_min,
   output logic [COORD_W-1:0] y_max,
   output logic               empty,
   output logic               complete,
   output logic               waiting,
   output logic [1:0]         stages_complete
);

   localparam int ZW = IMG_W / ZONES_X;
   localparam int ZH = IMG_H / ZONES_Y;
   localparam int NZ = ZONES_X * ZONES_Y;
   localparam int N  = IMG_W * IMG_H;

   typedef enum logic [1:0] {WAIT, SCAN, DRAIN, DONE} state_t;
   state_t state, state_nxt;

   logic [COORD_W-1:0] row, col, row_z, col_z;
   logic [ZSEL_W-1:0]  zx, zy;
   logic               valid_q;
   logic [COORD_W-1:0] row_q, col_q;
   logic [ZSEL_W-1:0]  zidx_q;
   logic               dark_q, found, ink, start, last_addr;
   logic [CNT_W-1:0]   zcnt [NZ];

   assign start     = (state == WAIT) && load;
   assign last_addr = (pixel_addr == ADDR_W'(N - 1));
   assign ink       = valid_q && (pixel == dark_q);

   always_ff @(posedge clk) begin
      if (!reset) state <= WAIT;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         WAIT:    if (load) state_nxt = SCAN;
         SCAN:    if (last_addr) state_nxt = DRAIN;
         DRAIN:   state_nxt = DONE;
         DONE:    if (!load) state_nxt = WAIT;
         default: state_nxt = WAIT;
      endcase
   end

   always_comb begin
      waiting         = 1'b0;
      complete        = 1'b0;
      stages_complete = 2'd0;
      case (state)
         WAIT:    waiting = 1'b1;
         SCAN:    stages_complete = 2'd1;
         DRAIN:   stages_complete = 2'd2;
         DONE:    begin complete = 1'b1; stages_complete = 2'd3; end
         default: waiting = 1'b1;
      endcase
   end

   // Row/col and zone coordinates step alongside the address so no divider is needed.
   always_ff @(posedge clk) begin
      if (!reset || start) begin
         pixel_addr <= '0;
         row <= '0; col <= '0; row_z <= '0; col_z <= '0;
         zx <= '0; zy <= '0;
      end else if (state == SCAN && !last_addr) begin
         pixel_addr <= pixel_addr + 1'b1;
         if (col == COORD_W'(IMG_W - 1)) begin
            col   <= '0;
            col_z <= '0;
            zx    <= '0;
            row   <= row + 1'b1;
            if (row_z == COORD_W'(ZH - 1)) begin
               row_z <= '0;
               zy    <= zy + 1'b1;
            end else begin
               row_z <= row_z + 1'b1;
            end
         end else begin
            col <= col + 1'b1;
            if (col_z == COORD_W'(ZW - 1)) begin
               col_z <= '0;
               zx    <= zx + 1'b1;
            end else begin
               col_z <= col_z + 1'b1;
            end
         end
      end
   end

   // Coordinates delayed one cycle to line up with the buffer's read latency.
   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_q <= 1'b0;
         row_q   <= '0;
         col_q   <= '0;
         zidx_q  <= '0;
      end else begin
         valid_q <= (state == SCAN);
         row_q   <= row;
         col_q   <= col;
         zidx_q  <= zy * ZSEL_W'(ZONES_X) + zx;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset || start) begin
         for (int unsigned i = 0; i < NZ; i++) zcnt[i] <= '0;
         total_count <= '0;
         x_min <= '0; x_max <= '0; y_min <= '0; y_max <= '0;
         found  <= 1'b0;
         empty  <= 1'b0;
         dark_q <= reset ? dark_level : 1'b0;
      end else begin
         if (ink) begin
            if (zcnt[zidx_q] != '1) zcnt[zidx_q] <= zcnt[zidx_q] + 1'b1;
            total_count <= total_count + 1'b1;
            found       <= 1'b1;
            if (!found) begin
               x_min <= col_q; x_max <= col_q;
               y_min <= row_q; y_max <= row_q;
            end else begin
               if (col_q < x_min) x_min <= col_q;
               if (col_q > x_max) x_max <= col_q;
               if (row_q < y_min) y_min <= row_q;
               if (row_q > y_max) y_max <= row_q;
            end
         end
         if (state == DRAIN) empty <= (total_count == '0) && !ink;
      end
   end

   always_comb begin
      zone_count = '0;
      if (32'(zone_sel) < NZ) zone_count = zcnt[zone_sel];
   end

endmodule

// File: tb/tb_pixel_zone_scanner.sv
// Directed bench for pixel_zone_scanner: default 28x28/4x4 instance plus a
// 16x16/2x2 instance with narrow counters to exercise saturation.
module tb_pixel_zone_scanner;

   logic       clk = 1'b0;
   logic       reset, load, dark_level, pixel;
   logic [9:0] pixel_addr;
   logic [3:0] zone_sel;
   logic [7:0] zone_count;
   logic [10:0] total_count;
   logic [4:0] x_min, x_max, y_min, y_max;
   logic       empty, complete, waiting;
   logic [1:0] stages_complete;

   logic       load2, pixel2;
   logic [7:0] pixel_addr2;
   logic [1:0] zone_sel2;
   logic [4:0] zone_count2;
   logic [8:0] total_count2;
   logic [3:0] x_min2, x_max2, y_min2, y_max2;
   logic       empty2, complete2, waiting2;
   logic [1:0] stages2;

   logic img  [1024];
   logic img2 [256];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      pixel  <= img[pixel_addr];
      pixel2 <= img2[pixel_addr2];
   end

   pixel_zone_scanner dut (
      .clk(clk), .reset(reset), .load(load), .dark_level(dark_level),
      .pixel(pixel), .pixel_addr(pixel_addr), .zone_sel(zone_sel),
      .zone_count(zone_count), .total_count(total_count),
      .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
      .empty(empty), .complete(complete), .waiting(waiting),
      .stages_complete(stages_complete)
   );

   pixel_zone_scanner #(
      .IMG_W(16), .IMG_H(16), .ZONES_X(2), .ZONES_Y(2),
      .ADDR_W(8), .COORD_W(4), .CNT_W(5), .ZSEL_W(2)
   ) dut_small (
      .clk(clk), .reset(reset), .load(load2), .dark_level(1'b0),
      .pixel(pixel2), .pixel_addr(pixel_addr2), .zone_sel(zone_sel2),
      .zone_count(zone_count2), .total_count(total_count2),
      .x_min(x_min2), .x_max(x_max2), .y_min(y_min2), .y_max(y_max2),
      .empty(empty2), .complete(complete2), .waiting(waiting2),
      .stages_complete(stages2)
   );

   task automatic fill_img(input logic v);
      for (int i = 0; i < 1024; i++) img[i] = v;
   endtask

   // Raise load, consume the load-sampling edge, then count edges to complete.
   task automatic run_scan(output int edges);
      @(negedge clk) load = 1'b1;
      @(posedge clk);
      edges = 0;
      while (edges < 2000) begin
         @(posedge clk);
         #1;
         edges++;
         if (complete) break;
      end
   endtask

   task automatic back_to_wait();
      @(negedge clk) load = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0; load = 1'b0; dark_level = 1'b0; zone_sel = '0;
      load2 = 1'b0; zone_sel2 = '0;
      fill_img(1'b1);
      for (int i = 0; i < 256; i++) img2[i] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (waiting !== 1'b1 || complete !== 1'b0 || stages_complete !== 2'd0 || empty !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags: waiting=%b complete=%b stages=%0d empty=%b, want 1 0 0 0",
                  waiting, complete, stages_complete, empty);
      end
      checks++;
      if (pixel_addr !== 10'd0 || total_count !== 11'd0 || zone_count !== 8'd0 ||
          x_max !== 5'd0 || y_max !== 5'd0) begin
         failures++;
         $display("FAIL reset_values: addr=%0d total=%0d zone=%0d xmax=%0d ymax=%0d, want all 0",
                  pixel_addr, total_count, zone_count, x_max, y_max);
      end
      @(negedge clk) reset = 1'b1;
   endtask

   task automatic test_background();
      int edges;
      fill_img(1'b1);
      dark_level = 1'b0;
      run_scan(edges);
      checks++;
      if (edges !== 785) begin
         failures++;
         $display("FAIL bg_latency: edges=%0d, want 785", edges);
      end
      for (int z = 0; z < 16; z++) begin
         zone_sel = 4'(z);
         #1;
         checks++;
         if (zone_count !== 8'd0) begin
            failures++;
            $display("FAIL bg_zone%0d: got %0d, want 0", z, zone_count);
         end
      end
      checks++;
      if (total_count !== 11'd0 || empty !== 1'b1 || x_min !== 5'd0 || x_max !== 5'd0 ||
          y_min !== 5'd0 || y_max !== 5'd0) begin
         failures++;
         $display("FAIL bg_summary: total=%0d empty=%b bbox=%0d..%0d,%0d..%0d, want 0 1 0..0,0..0",
                  total_count, empty, x_min, x_max, y_min, y_max);
      end
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (complete !== 1'b1 || stages_complete !== 2'd3) begin
         failures++;
         $display("FAIL bg_hold_done: complete=%b stages=%0d, want 1 3", complete, stages_complete);
      end
      back_to_wait();
   endtask

   task automatic test_single_pixel();
      int edges;
      fill_img(1'b1);
      img[270] = 1'b0;
      dark_level = 1'b0;
      run_scan(edges);
      checks++;
      if (edges !== 785) begin
         failures++;
         $display("FAIL single_latency: edges=%0d, want 785", edges);
      end
      for (int z = 0; z < 16; z++) begin
         zone_sel = 4'(z);
         #1;
         checks++;
         if (zone_count !== ((z == 6) ? 8'd1 : 8'd0)) begin
            failures++;
            $display("FAIL single_zone%0d: got %0d, want %0d", z, zone_count, (z == 6) ? 1 : 0);
         end
      end
      checks++;
      if (total_count !== 11'd1 || empty !== 1'b0 || x_min !== 5'd18 || x_max !== 5'd18 ||
          y_min !== 5'd9 || y_max !== 5'd9) begin
         failures++;
         $display("FAIL single_summary: total=%0d empty=%b bbox=%0d..%0d,%0d..%0d, want 1 0 18..18,9..9",
                  total_count, empty, x_min, x_max, y_min, y_max);
      end
      back_to_wait();
   endtask

   task automatic test_all_ink(input logic dark);
      int edges;
      fill_img(dark);
      dark_level = dark;
      run_scan(edges);
      dark_level = ~dark;
      checks++;
      if (edges !== 785) begin
         failures++;
         $display("FAIL ink%0d_latency: edges=%0d, want 785", dark, edges);
      end
      for (int z = 0; z < 16; z++) begin
         zone_sel = 4'(z);
         #1;
         checks++;
         if (zone_count !== 8'd49) begin
            failures++;
            $display("FAIL ink%0d_zone%0d: got %0d, want 49", dark, z, zone_count);
         end
      end
      checks++;
      if (total_count !== 11'd784 || empty !== 1'b0 || x_min !== 5'd0 || x_max !== 5'd27 ||
          y_min !== 5'd0 || y_max !== 5'd27) begin
         failures++;
         $display("FAIL ink%0d_summary: total=%0d empty=%b bbox=%0d..%0d,%0d..%0d, want 784 0 0..27,0..27",
                  dark, total_count, empty, x_min, x_max, y_min, y_max);
      end
      back_to_wait();
   endtask

   task automatic test_reset_mid_scan();
      int edges;
      fill_img(1'b0);
      dark_level = 1'b0;
      @(negedge clk) load = 1'b1;
      @(posedge clk);
      repeat (300) @(posedge clk);
      #1;
      checks++;
      if (total_count !== 11'd299 || pixel_addr !== 10'd300) begin
         failures++;
         $display("FAIL mid_progress: total=%0d addr=%0d, want 299 300", total_count, pixel_addr);
      end
      @(negedge clk) begin reset = 1'b0; load = 1'b0; end
      @(posedge clk);
      #1;
      zone_sel = 4'd0;
      #1;
      checks++;
      if (waiting !== 1'b1 || pixel_addr !== 10'd0 || total_count !== 11'd0 ||
          zone_count !== 8'd0 || stages_complete !== 2'd0) begin
         failures++;
         $display("FAIL mid_reset: waiting=%b addr=%0d total=%0d zone0=%0d stages=%0d, want 1 0 0 0 0",
                  waiting, pixel_addr, total_count, zone_count, stages_complete);
      end
      @(negedge clk) reset = 1'b1;
      fill_img(1'b1);
      img[0]   = 1'b0;
      img[783] = 1'b0;
      run_scan(edges);
      checks++;
      if (edges !== 785) begin
         failures++;
         $display("FAIL fresh_latency: edges=%0d, want 785", edges);
      end
      for (int z = 0; z < 16; z++) begin
         zone_sel = 4'(z);
         #1;
         checks++;
         if (zone_count !== ((z == 0 || z == 15) ? 8'd1 : 8'd0)) begin
            failures++;
            $display("FAIL fresh_zone%0d: got %0d, want %0d", z, zone_count,
                     (z == 0 || z == 15) ? 1 : 0);
         end
      end
      checks++;
      if (total_count !== 11'd2 || empty !== 1'b0 || x_min !== 5'd0 || x_max !== 5'd27 ||
          y_min !== 5'd0 || y_max !== 5'd27) begin
         failures++;
         $display("FAIL fresh_summary: total=%0d empty=%b bbox=%0d..%0d,%0d..%0d, want 2 0 0..27,0..27",
                  total_count, empty, x_min, x_max, y_min, y_max);
      end
      back_to_wait();
   endtask

   task automatic test_load_drop();
      int edges;
      fill_img(1'b1);
      dark_level = 1'b0;
      @(negedge clk) load = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (stages_complete !== 2'd1 || pixel_addr !== 10'd0) begin
         failures++;
         $display("FAIL drop_start: stages=%0d addr=%0d, want 1 0", stages_complete, pixel_addr);
      end
      edges = 0;
      @(negedge clk) load = 1'b0;
      while (edges < 2000) begin
         @(posedge clk);
         #1;
         edges++;
         if (complete) break;
      end
      checks++;
      if (edges !== 785 || total_count !== 11'd0 || empty !== 1'b1) begin
         failures++;
         $display("FAIL drop_complete: edges=%0d total=%0d empty=%b, want 785 0 1",
                  edges, total_count, empty);
      end
      @(posedge clk);
      #1;
      checks++;
      if (waiting !== 1'b1 || complete !== 1'b0 || empty !== 1'b1) begin
         failures++;
         $display("FAIL drop_wait: waiting=%b complete=%b empty=%b, want 1 0 1",
                  waiting, complete, empty);
      end
      @(negedge clk) load = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (stages_complete !== 2'd1 || pixel_addr !== 10'd0) begin
         failures++;
         $display("FAIL rescan_start: stages=%0d addr=%0d, want 1 0", stages_complete, pixel_addr);
      end
      @(posedge clk);
      #1;
      checks++;
      if (pixel_addr !== 10'd1) begin
         failures++;
         $display("FAIL rescan_addr: addr=%0d, want 1", pixel_addr);
      end
      @(negedge clk) reset = 1'b0;
      @(negedge clk) begin reset = 1'b1; load = 1'b0; end
   endtask

   task automatic test_small_variant();
      int edges;
      @(negedge clk) load2 = 1'b1;
      @(posedge clk);
      edges = 0;
      while (edges < 1000) begin
         @(posedge clk);
         #1;
         edges++;
         if (complete2) break;
      end
      checks++;
      if (edges !== 257) begin
         failures++;
         $display("FAIL small_latency: edges=%0d, want 257", edges);
      end
      for (int z = 0; z < 4; z++) begin
         zone_sel2 = 2'(z);
         #1;
         checks++;
         if (zone_count2 !== 5'd31) begin
            failures++;
            $display("FAIL small_zone%0d: got %0d, want 31", z, zone_count2);
         end
      end
      checks++;
      if (total_count2 !== 9'd256 || empty2 !== 1'b0 || x_min2 !== 4'd0 || x_max2 !== 4'd15 ||
          y_min2 !== 4'd0 || y_max2 !== 4'd15) begin
         failures++;
         $display("FAIL small_summary: total=%0d empty=%b bbox=%0d..%0d,%0d..%0d, want 256 0 0..15,0..15",
                  total_count2, empty2, x_min2, x_max2, y_min2, y_max2);
      end
      @(negedge clk) load2 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_background();
      test_single_pixel();
      test_all_ink(1'b0);
      test_all_ink(1'b1);
      test_reset_mid_scan();
      test_load_drop();
      test_small_variant();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
